// File: rtl/ov5640_sccb_ctrl.sv
// OV5640 SCCB write master: one 3-phase write (addr, reg16, val8)
// per cfg_start pulse, cfg_end pulse after STOP.
module ov5640_sccb_ctrl #(
  parameter logic [6:0] DEVICE_ADDR  = 7'h3C,
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter int         CNT_MAX      = SYS_CLK_FREQ / (SCL_FREQ * 4)
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] div;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   shreg;
  logic          err;
  logic          tick, last_q;
  logic          sda_low;
  logic [7:0]    tx_byte;
  logic          tx_bit;

  assign tick    = (state inside {S_START, S_BYTE, S_ACK, S_STOP})
                   && (div == DIV_LAST);
  assign last_q  = tick && (q == 2'd3);
  assign tx_byte = (byte_cnt == 2'd0) ? {DEVICE_ADDR, 1'b0}
                                      : shreg[23:16];
  assign tx_bit  = tx_byte[~bit_cnt];
  assign sda     = sda_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_n;
  end

  // Next state and bus line shapes per quarter
  always_comb begin
    state_n = state;
    scl     = 1'b1;
    sda_low = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg_start) state_n = S_START;
      end
      S_START: begin
        scl     = (q != 2'd3);
        sda_low = q[1];
        if (last_q) state_n = S_BYTE;
      end
      S_BYTE: begin
        scl     = q[0] ^ q[1];
        sda_low = ~tx_bit;
        if (last_q && bit_cnt == 3'd7) state_n = S_ACK;
      end
      S_ACK: begin
        scl = q[0] ^ q[1];
        if (last_q)
          state_n = (byte_cnt == 2'd3) ? S_STOP : S_BYTE;
      end
      S_STOP: begin
        scl     = (q != 2'd0);
        sda_low = ~q[1];
        if (last_q) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Divider, quarter/bit/byte counters, data shifter and status
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div      <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      err      <= 1'b0;
      ack_err  <= 1'b0;
      cfg_end  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cfg_end <= 1'b0;
      if (cfg_end) busy <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            shreg    <= cfg_data;
            busy     <= 1'b1;
            ack_err  <= 1'b0;
            err      <= 1'b0;
            div      <= '0;
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        S_DONE: begin
          cfg_end <= 1'b1;
          ack_err <= err;
        end
        default: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) q <= q + 2'd1;
          if (state == S_ACK && tick && q == 2'd1)
            err <= err | sda;
          if (last_q && state == S_BYTE)
            bit_cnt <= bit_cnt + 3'd1;
          if (last_q && state == S_ACK) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt != 2'd0)
              shreg <= {shreg[15:0], 8'h00};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_sccb_ctrl.sv
// Bench for ov5640_sccb_ctrl: bus decoder + ACKing slave per instance,
// directed and random writes checked against a byte/timing model.
module tb_ov5640_sccb_ctrl;

  localparam int CM0 = 50;

  logic        sys_clk = 1'b0;
  logic        rst_n     [3];
  logic        cfg_start [3];
  logic [23:0] cfg_data  [3];
  logic        ack_en    [3];
  int          checks   = 0;
  int          failures = 0;

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int CM = (g == 0) ? 50 : (g == 1) ? 2 : 125;
    logic       scl, cfg_end, busy, ack_err;
    logic       slave_low = 1'b0;
    wire        sda_w;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       in_frame = 1'b0;
    logic [3:0] bitcnt = '0;
    logic [7:0] sh = '0;
    logic [7:0] bytes [64];
    logic       acks  [64];
    int         nb = 0, nstart = 0, nstop = 0, nend = 0;
    time        t_end = 0;

    pullup pu (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    ov5640_sccb_ctrl #(.CNT_MAX(CM)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(rst_n[g]),
      .cfg_start(cfg_start[g]),
      .cfg_data (cfg_data[g]),
      .cfg_end  (cfg_end),
      .busy     (busy),
      .ack_err  (ack_err),
      .scl      (scl),
      .sda      (sda_w)
    );

    // Bus decoder and slave, sampled mid-cycle
    always @(negedge sys_clk) begin
      if (!rst_n[g]) begin
        in_frame  <= 1'b0;
        bitcnt    <= '0;
        slave_low <= 1'b0;
        p_scl     <= 1'b1;
        p_sda     <= 1'b1;
      end else begin
        if (cfg_end) begin
          nend  <= nend + 1;
          t_end <= $time - 5;
        end
        if (p_scl && scl && p_sda && !sda_w) begin
          in_frame <= 1'b1;
          bitcnt   <= '0;
          nstart   <= nstart + 1;
        end else if (p_scl && scl && !p_sda && sda_w) begin
          in_frame <= 1'b0;
          nstop    <= nstop + 1;
        end else if (!p_scl && scl && in_frame) begin
          if (bitcnt == 4'd8) begin
            if (nb > 0 && nb <= 64) acks[nb-1] <= sda_w;
            bitcnt <= '0;
          end else begin
            sh <= {sh[6:0], sda_w};
            if (bitcnt == 4'd7) begin
              if (nb < 64) bytes[nb] <= {sh[6:0], sda_w};
              nb <= nb + 1;
            end
            bitcnt <= bitcnt + 4'd1;
          end
        end
        if (p_scl && !scl)
          slave_low <= in_frame && ack_en[g] && (bitcnt == 4'd8);
        p_scl <= scl;
        p_sda <= sda_w;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [23:0] d,
                                          input int k);
    logic [31:0] f;
    f = {8'h78, d};
    return f[8*(3-k) +: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [23:0] d, output time tacc);
    @(posedge sys_clk);
    #1;
    cfg_start[0] = 1'b1;
    cfg_data[0]  = d;
    @(posedge sys_clk);
    tacc = $time;
    #1;
    cfg_start[0] = 1'b0;
    cfg_data[0]  = 24'($urandom);
  endtask

  task automatic wait_end(input string tag, output time te);
    bit seen;
    seen = 1'b0;
    te   = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge sys_clk);
      if (gi[0].cfg_end === 1'b1) begin
        seen = 1'b1;
        te   = $time - 5;
      end
    end
    chk({tag, "_end_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic check_txn(input string tag, input logic [23:0] d,
                           input int nb0, input time ta,
                           input time te);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_byte%0d", tag, k),
          64'(gi[0].bytes[nb0+k]), 64'(exp_byte(d, k)));
    chk({tag, "_len"}, 64'((te - ta) / 10), 64'(152 * CM0 + 1));
  endtask

  initial begin
    time         ta, te, ta_sw;
    time         tas [3];
    time         tes [3];
    int          nb0, s0, p0, e0;
    logic [23:0] d, d1, d2;
    logic [23:0] ds [3];
    bit          got;

    for (int g = 0; g < 3; g++) begin
      rst_n[g]     = 1'b0;
      cfg_start[g] = 1'b0;
      cfg_data[g]  = '0;
      ack_en[g]    = 1'b1;
    end
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_scl", 64'(gi[0].scl), 64'd1);
    chk("rst_sda", 64'(gi[0].sda_w), 64'd1);
    chk("rst_end", 64'(gi[0].cfg_end), 64'd0);
    chk("rst_busy", 64'(gi[0].busy), 64'd0);
    chk("rst_ackerr", 64'(gi[0].ack_err), 64'd0);
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    repeat (3) @(posedge sys_clk);

    // single write with ACK, sweep instances start alongside
    d1  = 24'($urandom);
    d2  = 24'($urandom);
    nb0 = gi[0].nb;
    s0  = gi[0].nstart;
    p0  = gi[0].nstop;
    e0  = gi[0].nend;
    @(posedge sys_clk);
    #1;
    cfg_start[0] = 1'b1; cfg_data[0] = 24'h300882;
    cfg_start[1] = 1'b1; cfg_data[1] = d1;
    cfg_start[2] = 1'b1; cfg_data[2] = d2;
    @(posedge sys_clk);
    ta    = $time;
    ta_sw = $time;
    #1;
    for (int g = 0; g < 3; g++) begin
      cfg_start[g] = 1'b0;
      cfg_data[g]  = 24'($urandom);
    end
    chk("a_busy", 64'(gi[0].busy), 64'd1);
    wait_end("a", te);
    chk("a_busy_at_end", 64'(gi[0].busy), 64'd1);
    @(negedge sys_clk);
    chk("a_busy_after", 64'(gi[0].busy), 64'd0);
    check_txn("a", 24'h300882, nb0, ta, te);
    chk("a_ackerr", 64'(gi[0].ack_err), 64'd0);
    repeat (20) @(negedge sys_clk);
    chk("a_nend", 64'(gi[0].nend - e0), 64'd1);
    chk("a_nstart", 64'(gi[0].nstart - s0), 64'd1);
    chk("a_nstop", 64'(gi[0].nstop - p0), 64'd1);

    // no slave: all bytes still sent, error flagged
    ack_en[0] = 1'b0;
    nb0 = gi[0].nb;
    p0  = gi[0].nstop;
    do_start(24'h310311, ta);
    wait_end("b", te);
    @(negedge sys_clk);
    check_txn("b", 24'h310311, nb0, ta, te);
    chk("b_ackerr", 64'(gi[0].ack_err), 64'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("b_nack%0d", k), 64'(gi[0].acks[nb0+k]), 64'd1);
    chk("b_nstop", 64'(gi[0].nstop - p0), 64'd1);
    ack_en[0] = 1'b1;

    // following ACKed write clears the error
    d   = 24'($urandom);
    nb0 = gi[0].nb;
    do_start(d, ta);
    wait_end("c", te);
    @(negedge sys_clk);
    check_txn("c", d, nb0, ta, te);
    chk("c_ackerr", 64'(gi[0].ack_err), 64'd0);
    chk("c_ack0", 64'(gi[0].acks[nb0]), 64'd0);

    // start and data changes while busy are ignored
    d   = 24'($urandom);
    nb0 = gi[0].nb;
    e0  = gi[0].nend;
    do_start(d, ta);
    repeat (1000) @(posedge sys_clk);
    #1;
    cfg_start[0] = 1'b1;
    cfg_data[0]  = 24'hFFFFFF;
    @(posedge sys_clk);
    #1;
    cfg_start[0] = 1'b0;
    chk("i_busy", 64'(gi[0].busy), 64'd1);
    wait_end("i", te);
    @(negedge sys_clk);
    check_txn("i", d, nb0, ta, te);
    repeat (20) @(negedge sys_clk);
    chk("i_nend", 64'(gi[0].nend - e0), 64'd1);
    chk("i_busy_after", 64'(gi[0].busy), 64'd0);

    // generator-style back-to-back writes
    ds[0] = 24'h310311;
    ds[1] = 24'h300882;
    ds[2] = 24'h300842;
    nb0 = gi[0].nb;
    e0  = gi[0].nend;
    for (int i = 0; i < 3; i++) begin
      do_start(ds[i], tas[i]);
      wait_end($sformatf("bb%0d", i), tes[i]);
    end
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++)
      check_txn($sformatf("bb%0d", i), ds[i], nb0 + 4*i, tas[i], tes[i]);
    for (int i = 0; i < 2; i++)
      chk($sformatf("bb_gap%0d", i), 64'((tas[i+1] - tes[i]) / 10),
          64'd2);
    chk("bb_nend", 64'(gi[0].nend - e0), 64'd3);

    // reset in the middle of the third byte
    nb0 = gi[0].nb;
    do_start(24'($urandom), ta);
    got = 1'b0;
    for (int i = 0; i < 8000 && !got; i++) begin
      @(posedge sys_clk);
      if (gi[0].nb >= nb0 + 2) got = 1'b1;
    end
    chk("r_reach_byte2", 64'(got), 64'd1);
    repeat (1050) @(posedge sys_clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("r_scl", 64'(gi[0].scl), 64'd1);
    chk("r_sda", 64'(gi[0].sda_w), 64'd1);
    chk("r_busy", 64'(gi[0].busy), 64'd0);
    chk("r_end", 64'(gi[0].cfg_end), 64'd0);
    e0 = gi[0].nend;
    repeat (5) @(negedge sys_clk);
    rst_n[0] = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("r_no_end", 64'(gi[0].nend - e0), 64'd0);
    d   = 24'($urandom);
    nb0 = gi[0].nb;
    do_start(d, ta);
    wait_end("r2", te);
    @(negedge sys_clk);
    check_txn("r2", d, nb0, ta, te);
    chk("r2_ackerr", 64'(gi[0].ack_err), 64'd0);

    // parameter sweep instances ran alongside the first write
    chk("s2_nend", 64'(gi[1].nend), 64'd1);
    chk("s2_len", 64'((gi[1].t_end - ta_sw) / 10), 64'(152 * 2 + 1));
    chk("s125_nend", 64'(gi[2].nend), 64'd1);
    chk("s125_len", 64'((gi[2].t_end - ta_sw) / 10), 64'(152 * 125 + 1));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s2_byte%0d", k), 64'(gi[1].bytes[k]),
          64'(exp_byte(d1, k)));
      chk($sformatf("s125_byte%0d", k), 64'(gi[2].bytes[k]),
          64'(exp_byte(d2, k)));
    end
    chk("s2_ackerr", 64'(gi[1].ack_err), 64'd0);
    chk("s125_ackerr", 64'(gi[2].ack_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov5640_sccb_ctrl.md
# ov5640_sccb_ctrl

SCCB (I2C-compatible) write master for OV5640 camera register programming. It sits directly downstream of the OV5640 register-sequence generator. For each one-cycle `cfg_start` pulse it writes one 8-bit value to one 16-bit sensor register. It returns a one-cycle `cfg_end` pulse when the bus transaction, including STOP, is complete.

## Interface
- `DEVICE_ADDR`, default 7'h3C: 7-bit SCCB slave address. The first byte on the bus is {DEVICE_ADDR, 1'b0} = 8'h78.
- `SYS_CLK_FREQ`, default 50_000_000: sys_clk frequency in Hz.
- `SCL_FREQ`, default 250_000: SCL frequency in Hz.
- `CNT_MAX`, default SYS_CLK_FREQ/(SCL_FREQ*4) = 50: sys_clk cycles per SCL quarter-period. Must be >= 2.

Ports:
- `sys_clk`  in  1: system clock.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `cfg_start`  in  1: one-cycle request to start a write.
- `cfg_data`  in  24: {reg_addr[15:0], reg_val[7:0]}. Sampled only on an accepted `cfg_start`.
- `cfg_end`  out  1: one-cycle pulse when the transaction is finished.
- `busy`  out  1: high from acceptance until `cfg_end`, inclusive.
- `ack_err`  out  1: result flag for the last transaction. High if any ACK slot sampled SDA=1.
- `scl`  out  1: SCCB clock, push-pull.
- `sda`  inout  1: SCCB data, open-drain. The block only ever drives 0; a logic 1 is released as 'z'. An external pull-up is required.

## Operation
- **Reset values:** state IDLE, `scl`=1, `sda` released, `cfg_end`=0, `busy`=0, `ack_err`=0, all counters 0.
- **Acceptance:** `cfg_start`=1 while in IDLE latches `cfg_data` into a 24-bit shift register and sets `busy`. It also clears `ack_err`, resets the quarter divider and enters START. `cfg_start` while busy is ignored. Changes to `cfg_data` after acceptance have no effect.
- **Quarter tick:** the divider counts 0..CNT_MAX-1. The tick fires at CNT_MAX-1 and each tick advances a 2-bit quarter counter q. All line changes occur on tick boundaries.
- **States:** IDLE → START → BYTE → ACK → (BYTE, next byte | STOP) → DONE → IDLE.
- **START** (4 quarters):
  - q0, q1: SCL=1, SDA=1
  - q2: SCL=1, SDA=0
  - q3: SCL=0, SDA=0
- **BYTE** (8 bits × 4 quarters, MSB first). Per bit:
  - q0: SCL=0, SDA set to the bit value
  - q1, q2: SCL=1
  - q3: SCL=0
- **Byte order:** byte counter 0..3 sends 8'h78, reg_addr[15:8], reg_addr[7:0], reg_val.
- **ACK** (4 quarters): SDA is released and uses the same SCL shape as a data bit. SDA is sampled at the last sys_clk of q1. A sample of 1 sets the internal error bit.
- **ACK policy:** per SCCB, a missing ACK does not abort the transfer. All 4 bytes are always sent.
- **STOP** (4 quarters):
  - q0: SCL=0, SDA=0
  - q1: SCL=1, SDA=0
  - q2, q3: SCL=1, SDA=1
- **DONE** (1 sys_clk):
  - `cfg_end`=1 and `ack_err` updated from the error bit.
  - State returns to IDLE on the same edge that asserts `cfg_end`.
  - `busy` deasserts the following cycle.
- **Reset mid-transaction:** everything returns to reset values immediately and no `cfg_end` is produced. The slave is left in an unspecified state; this is accepted because reset also restarts the upstream sequence.

## Timing
- **Transaction length:** START (1 slot) + 4 × (8+1) slots + STOP (1 slot) = 38 slots = 152 quarters = 152·CNT_MAX sys_clk cycles. At default parameters this is 7600 cycles.
- **Start of bus activity:** START q0 begins the cycle after acceptance.
- **End pulse:** `cfg_end` rises 152·CNT_MAX+1 cycles after the `cfg_start` sample edge.
- **Back-to-back requests:** `cfg_start` asserted in the cycle after `cfg_end` must be accepted with no lost cycle. The upstream generator issues its next request exactly then.
- **SCL shape:** 50% duty within data and ACK slots. At defaults SCL high = 2·CNT_MAX = 100 cycles (2 µs) and SCL period = 4 µs.
- **SDA stability:** SDA never changes while SCL=1, except for the START and STOP edges.

## Test plan
- **Single write with ACK:** reset, then `cfg_start` with `cfg_data`=24'h300882; the slave model ACKs every byte. Bus bytes must be 78, 30, 08, 82 with correct START/STOP. `cfg_end` must pulse exactly once, 7601 cycles after acceptance, with `ack_err`=0 and `busy` low afterwards.
- **No ACK:** pull-up only, no slave, `cfg_data`=24'h310311. All 4 bytes must still appear on the bus, followed by STOP. `cfg_end` must pulse and `ack_err` must read 1. A following write with ACKs must clear `ack_err` to 0.
- **Busy immunity:** during a transfer, pulse `cfg_start` again and change `cfg_data` to 24'hFFFFFF. The bus bytes must be unchanged and only one `cfg_end` produced.
- **Back-to-back:** drive a generator-style model that issues the next `cfg_start` in the cycle after `cfg_end`, for 3 writes (3103/11, 3008/82, 3008/42). Expect 3 complete transactions with no idle gap beyond 1 cycle and 3 `cfg_end` pulses.
- **Reset mid-byte:** assert `sys_rst_n`=0 during the third byte. `scl` must go to 1 and `sda` to 'z' within 0 cycles (asynchronously), with no `cfg_end`. After release, a new write must complete normally.
- **Parameter sweep:** CNT_MAX=2 and CNT_MAX=125. Transaction length must be 304 and 19000 cycles respectively, and bus bytes must be correct.
